// File: rtl/if_stage_pkg.sv
// ============================================================================
// if_stage_pkg : shared widths, reset defaults and FSM encoding for fetch
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

  localparam int CPU_WIDTH = 32;

  localparam logic [CPU_WIDTH-1:0] RESET_PC_DEF  = 32'h0000_0000;
  // addi x0,x0,0
  localparam logic [CPU_WIDTH-1:0] NOP_INST_DEF  = 32'h0000_0013;
  localparam logic [CPU_WIDTH-1:0] PC_STEP       = 32'h0000_0004;
  localparam logic [CPU_WIDTH-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

endpackage : if_stage_pkg

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// if_id_reg : IF/ID pipeline register with hold and bubble (NOP) insertion
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_hold,
  input  logic                 i_bubble,
  input  logic [CPU_WIDTH-1:0] i_pc,
  input  logic [CPU_WIDTH-1:0] i_inst,
  output logic [CPU_WIDTH-1:0] o_pc,
  output logic [CPU_WIDTH-1:0] o_inst,
  output logic                 o_valid
);

  logic [CPU_WIDTH-1:0] r_pc;
  logic [CPU_WIDTH-1:0] r_inst;
  logic                 r_valid;

  // A bubble outranks a hold so a flush still squashes a stalled slot.
  always_ff @(posedge clk) begin
    if (!rst_n || i_bubble) begin
      r_pc    <= '0;
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      r_pc    <= i_pc;
      r_inst  <= i_inst;
      r_valid <= 1'b1;
    end
  end

  assign o_pc    = r_pc;
  assign o_inst  = r_inst;
  assign o_valid = r_valid;

endmodule : if_id_reg

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// if_stage : instruction fetch - PC register, boot/run/hold FSM, fetch counter
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [CPU_WIDTH-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_i,
  input  logic                 jump_en_i,
  input  logic [CPU_WIDTH-1:0] jump_addr_i,
  input  logic                 flush_i,
  output logic [CPU_WIDTH-1:0] pc_addr_o,
  input  logic [CPU_WIDTH-1:0] inst_i,
  output logic [CPU_WIDTH-1:0] id_pc_o,
  output logic [CPU_WIDTH-1:0] id_inst_o,
  output logic                 id_valid_o,
  output logic [CPU_WIDTH-1:0] fetch_cnt_o
);

  fetch_state_t         r_state;
  fetch_state_t         w_state_nxt;
  logic [CPU_WIDTH-1:0] r_pc;
  logic [CPU_WIDTH-1:0] w_pc_nxt;
  logic [CPU_WIDTH-1:0] r_fetch_cnt;
  logic [CPU_WIDTH-1:0] w_fetch_cnt_nxt;
  logic                 w_bubble;
  logic                 w_hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_PC;
      r_fetch_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_fetch_cnt <= w_fetch_cnt_nxt;
    end
  end

  // RUN and HOLD share one decision tree; HOLD only records that the
  // previous cycle was stalled, so releasing stall advances immediately.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_fetch_cnt_nxt = r_fetch_cnt;
    w_bubble        = 1'b0;
    w_hold          = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_RUN;
        w_bubble    = 1'b1;
      end
      default: begin
        if (jump_en_i) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = jump_addr_i & PC_ALIGN_MASK;
          w_bubble    = 1'b1;
        end else begin
          if (stall_i) begin
            w_state_nxt = S_HOLD;
            w_hold      = 1'b1;
          end else begin
            w_state_nxt = S_RUN;
            w_pc_nxt    = r_pc + PC_STEP;
          end
          if (flush_i) begin
            w_bubble = 1'b1;
          end else if (!stall_i) begin
            w_fetch_cnt_nxt = r_fetch_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_hold   (w_hold),
    .i_bubble (w_bubble),
    .i_pc     (r_pc),
    .i_inst   (inst_i),
    .o_pc     (id_pc_o),
    .o_inst   (id_inst_o),
    .o_valid  (id_valid_o)
  );

  assign pc_addr_o   = r_pc;
  assign fetch_cnt_o = r_fetch_cnt;

endmodule : if_stage

`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0): bubble word.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 stall_i  input  1  hazard hold from decode/control; freeze PC and IF/ID.
REQ-006 jump_en_i  input  1  redirect request (branch taken / jal / jalr).
REQ-007 jump_addr_i  input  CPU_WIDTH  redirect target.
REQ-008 flush_i  input  1  squash IF/ID contents without redirect.
REQ-009 pc_addr_o  output  CPU_WIDTH  fetch address to instruction memory.
REQ-010 inst_i  input  CPU_WIDTH  instruction word from instruction memory, combinational from pc_addr_o.
REQ-011 id_pc_o  output  CPU_WIDTH  PC of instruction held in IF/ID.
REQ-012 id_inst_o  output  CPU_WIDTH  instruction held in IF/ID.
REQ-013 id_valid_o  output  1  IF/ID holds a real instruction.
REQ-014 fetch_cnt_o  output  CPU_WIDTH  count of instructions accepted into IF/ID.

Function
REQ-015 pc_addr_o SHALL be driven directly from the PC register, no combinational path from any input.
REQ-016 FSM states: BOOT, RUN, HOLD; BOOT entered on reset, lasts exactly one cycle, then RUN.
REQ-017 In BOOT: PC holds RESET_PC, IF/ID loads NOP_INST with id_valid_o=0.
REQ-018 RUN with no stall/jump/flush: PC <= PC+4; IF/ID <= {pc_addr_o, inst_i}, id_valid_o=1; fetch_cnt_o increments by 1.
REQ-019 Fetch latency: instruction at address A appears on id_inst_o exactly one cycle after pc_addr_o==A.
REQ-020 stall_i=1 (no jump): RUN->HOLD; PC, IF/ID, id_valid_o, fetch_cnt_o unchanged; HOLD->RUN when stall_i=0.
REQ-021 jump_en_i=1: PC <= {jump_addr_i[31:2],2'b00}; IF/ID <= NOP_INST, id_valid_o=0; fetch_cnt_o unchanged; next state RUN.
REQ-022 Priority: rst_n low > jump_en_i > flush_i > stall_i > normal advance.
REQ-023 jump_en_i and stall_i together: jump wins, HOLD exited immediately.
REQ-024 flush_i without jump: PC advances per stall/normal rules, IF/ID <= NOP_INST, id_valid_o=0, no count.
REQ-025 PC+4 SHALL wrap modulo 2^CPU_WIDTH (32'hFFFF_FFFC -> 32'h0000_0000), no error signalled.
REQ-026 fetch_cnt_o SHALL wrap modulo 2^CPU_WIDTH.
REQ-027 Jump or flush during BOOT SHALL be ignored; BOOT always completes.

Reset
REQ-028 While rst_n=0 at a rising edge: PC=RESET_PC, state=BOOT, id_pc_o=0, id_inst_o=NOP_INST, id_valid_o=0, fetch_cnt_o=0.
REQ-029 Reset asserted mid-stall or mid-jump SHALL discard the pending operation; no state survives.
REQ-030 Outputs SHALL change only at clock edges, including reset entry and exit.

Structure
REQ-031 CPU_WIDTH, RESET_PC default, NOP_INST encoding and FSM state encodings SHALL live in the shared defines file.
REQ-032 One sub-module if_id_reg (pipeline register with stall/flush/NOP insert) SHALL be instantiated; PC, FSM and counter stay in if_stage.
REQ-033 if_stage SHALL connect to the existing instruction memory with no glue logic: pc_addr_o to its address input, inst_i from its instruction output.

Verification
REQ-034 Reset release, memory preloaded 0x00..0x0C -> pc_addr_o 0,0,4,8,C; id_valid_o 0 then 1; id_pc_o 0,4,8 one cycle behind.
REQ-035 stall_i high 3 cycles at PC=0x8 -> pc_addr_o stays 0x8, id_pc_o stays 0x4, fetch_cnt_o frozen; resumes at 0xC.
REQ-036 jump_en_i pulse, jump_addr_i=0x103 at PC=0x10 -> next pc_addr_o=0x100, id_valid_o=0 one cycle, then id_pc_o=0x100.
REQ-037 jump_en_i and stall_i high same cycle -> jump taken, pc_addr_o=target next cycle, state RUN.
REQ-038 Force PC to 0xFFFF_FFFC via jump -> next pc_addr_o=0x0000_0000.
REQ-039 rst_n low during HOLD -> next cycle pc_addr_o=RESET_PC, id_valid_o=0, fetch_cnt_o=0, BOOT then RUN.
